// File: rtl/zoram_dram_sched_if.sv
// Bus-side signal bundle for the FastRAM DRAM scheduler.
// The master side (bus decode) drives the access request and strobes.
// The slave side (scheduler) drives the DRAM strobes and status.
interface zoram_dram_sched_if;
  logic       acc_req;
  logic       acc_wr;
  logic       acc_uds;
  logic       acc_lds;
  logic       ras;
  logic       ucas;
  logic       lcas;
  logic       mux_col;
  logic       we;
  logic       acc_ack;
  logic [2:0] ref_pend;
  logic       busy;

  modport master (
    output acc_req, acc_wr, acc_uds, acc_lds,
    input  ras, ucas, lcas, mux_col, we, acc_ack, ref_pend, busy
  );

  modport slave (
    input  acc_req, acc_wr, acc_uds, acc_lds,
    output ras, ucas, lcas, mux_col, we, acc_ack, ref_pend, busy
  );
endinterface

// File: rtl/zoram_dram_sched.sv
// FastRAM DRAM cycle scheduler: interleaves bus accesses with CAS-before-RAS
// refresh. All DRAM strobes come from flops loaded from the next-state
// decode, so they change cleanly on the clock edge.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | no cycle in progress; arbitrate access vs. owed refresh
// ACC_ROW   | RAS high, row address on MADDR; write flag captured
// ACC_COL   | column address on MADDR; WE set up ahead of CAS
// ACC_CAS   | lane CAS strobes high, ACK to the bus; held while requested
// REF_CAS   | both CAS high with RAS low (CAS-before-RAS setup)
// REF_RAS   | RAS joins CAS for two clocks; one owed refresh retired
// PRECHG    | all strobes low for RP_CYCLES clocks
module zoram_dram_sched #(
  parameter int REF_INTERVAL = 108,
  parameter int RP_CYCLES    = 2,
  parameter int REF_MAX_PEND = 4
) (
  input logic               CLK,
  input logic               RESET,
  zoram_dram_sched_if.slave bus
);

  localparam int TW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam int CW = (RP_CYCLES > 1) ? $clog2(RP_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMR_RELOAD = TW'(REF_INTERVAL - 1);
  localparam logic [CW-1:0] RP_LOAD    = CW'(RP_CYCLES - 1);
  localparam logic [2:0]    PEND_MAX   = 3'(REF_MAX_PEND);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC_ROW,
    S_ACC_COL,
    S_ACC_CAS,
    S_REF_CAS,
    S_REF_RAS,
    S_PRECHG
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    pend, pend_n;
  logic          wr_lat, wr_lat_n;
  logic          tick, ref_dec;

  logic ras_q, ucas_q, lcas_q, mux_q, we_q, ack_q, busy_q;
  logic ras_n, ucas_n, lcas_n, mux_n, we_n, ack_n, busy_n;

  // Next-state, dwell counter and write-flag capture.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    wr_lat_n = wr_lat;
    case (state)
      S_IDLE: begin
        // A saturated backlog beats the bus; otherwise the bus wins a tie.
        if (pend == PEND_MAX || (pend != 3'd0 && !bus.acc_req)) begin
          state_n = S_REF_CAS;
        end else if (bus.acc_req) begin
          state_n  = S_ACC_ROW;
          wr_lat_n = bus.acc_wr;
        end
      end
      S_ACC_ROW: state_n = bus.acc_req ? S_ACC_COL : S_PRECHG;
      S_ACC_COL: state_n = bus.acc_req ? S_ACC_CAS : S_PRECHG;
      S_ACC_CAS: if (!bus.acc_req) state_n = S_PRECHG;
      S_REF_CAS: begin
        state_n = S_REF_RAS;
        cnt_n   = CW'(1);
      end
      S_REF_RAS: begin
        if (cnt == '0) state_n = S_PRECHG;
        else           cnt_n   = cnt - CW'(1);
      end
      S_PRECHG: begin
        if (cnt == '0) state_n = S_IDLE;
        else           cnt_n   = cnt - CW'(1);
      end
      default: state_n = S_IDLE;
    endcase
    if (state_n == S_PRECHG && state != S_PRECHG) cnt_n = RP_LOAD;
  end

  // Refresh timer and owed-refresh bookkeeping; a tick and a retire cancel.
  always_comb begin
    tick    = (timer == '0);
    ref_dec = (state == S_REF_CAS) && (state_n == S_REF_RAS);
    timer_n = tick ? TMR_RELOAD : timer - TW'(1);
    pend_n  = pend;
    if (tick && !ref_dec) begin
      if (pend != PEND_MAX) pend_n = pend + 3'd1;
    end else if (!tick && ref_dec) begin
      pend_n = pend - 3'd1;
    end
  end

  // Strobe decode from the state being entered, so the flops hold it for the whole state.
  always_comb begin
    ras_n  = 1'b0;
    ucas_n = 1'b0;
    lcas_n = 1'b0;
    mux_n  = 1'b0;
    we_n   = 1'b0;
    ack_n  = 1'b0;
    busy_n = (state_n != S_IDLE);
    case (state_n)
      S_ACC_ROW: ras_n = 1'b1;
      S_ACC_COL: begin
        ras_n = 1'b1;
        mux_n = 1'b1;
        we_n  = wr_lat_n;
      end
      S_ACC_CAS: begin
        ras_n  = 1'b1;
        mux_n  = 1'b1;
        we_n   = wr_lat_n;
        ucas_n = bus.acc_uds;
        lcas_n = bus.acc_lds;
        ack_n  = bus.acc_uds | bus.acc_lds;
      end
      S_REF_CAS: begin
        ucas_n = 1'b1;
        lcas_n = 1'b1;
      end
      S_REF_RAS: begin
        ras_n  = 1'b1;
        ucas_n = 1'b1;
        lcas_n = 1'b1;
      end
      default: ;
    endcase
  end

  // State, timer and output registers; reset aborts any cycle in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= S_IDLE;
      cnt    <= '0;
      timer  <= TMR_RELOAD;
      pend   <= 3'd0;
      wr_lat <= 1'b0;
      ras_q  <= 1'b0;
      ucas_q <= 1'b0;
      lcas_q <= 1'b0;
      mux_q  <= 1'b0;
      we_q   <= 1'b0;
      ack_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      timer  <= timer_n;
      pend   <= pend_n;
      wr_lat <= wr_lat_n;
      ras_q  <= ras_n;
      ucas_q <= ucas_n;
      lcas_q <= lcas_n;
      mux_q  <= mux_n;
      we_q   <= we_n;
      ack_q  <= ack_n;
      busy_q <= busy_n;
    end
  end

  assign bus.ras      = ras_q;
  assign bus.ucas     = ucas_q;
  assign bus.lcas     = lcas_q;
  assign bus.mux_col  = mux_q;
  assign bus.we       = we_q;
  assign bus.acc_ack  = ack_q;
  assign bus.busy     = busy_q;
  assign bus.ref_pend = pend;

endmodule

// File: tb/tb_zoram_dram_sched.sv
// Directed bench for the DRAM scheduler with a short refresh interval.
// Output vector order: {ras, ucas, lcas, mux_col, we, acc_ack, busy}.
module tb_zoram_dram_sched;
  logic clk;
  logic reset;
  int   cyc;
  int   vectors;
  int   miscompares;
  logic [2:0] maxp;

  zoram_dram_sched_if bus_if ();

  zoram_dram_sched #(
    .REF_INTERVAL(16),
    .RP_CYCLES   (2),
    .REF_MAX_PEND(4)
  ) dut (
    .CLK  (clk),
    .RESET(reset),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {bus_if.ras, bus_if.ucas, bus_if.lcas, bus_if.mux_col,
            bus_if.we, bus_if.acc_ack, bus_if.busy};
  endfunction

  task automatic chk_o(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = outs();
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cycle %0d outputs observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_p(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cycle %0d ref_pend observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic set_bus(input logic req, input logic wr, input logic uds, input logic lds);
    bus_if.acc_req = req;
    bus_if.acc_wr  = wr;
    bus_if.acc_uds = uds;
    bus_if.acc_lds = lds;
  endtask

  // The reset edge is cycle 0; cycle n is sampled 1 time unit after edge n.
  task automatic do_reset();
    reset = 1'b1;
    set_bus(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    reset       = 1'b1;
    set_bus(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Idle refresh after reset
    do_reset();
    chk_o("rst_outs", 7'b0000000);
    chk_p("rst_pend", bus_if.ref_pend, 3'd0);
    tick_to(15);
    chk_p("ref_pend_15", bus_if.ref_pend, 3'd0);
    tick_to(16);
    chk_p("ref_pend_16", bus_if.ref_pend, 3'd1);
    chk_o("ref_idle_16", 7'b0000000);
    tick_to(17);
    chk_o("ref_cas_17", 7'b0110001);
    tick_to(18);
    chk_o("ref_ras_18", 7'b1110001);
    chk_p("ref_dec_18", bus_if.ref_pend, 3'd0);
    tick_to(19);
    chk_o("ref_ras_19", 7'b1110001);
    tick_to(20);
    chk_o("ref_pre_20", 7'b0000001);
    tick_to(21);
    chk_o("ref_pre_21", 7'b0000001);
    tick_to(22);
    chk_o("ref_idle_22", 7'b0000000);

    // Read, both lanes, request from cycle 10 to 19
    do_reset();
    tick_to(9);
    set_bus(1'b1, 1'b0, 1'b1, 1'b1);
    tick_to(10);
    chk_o("rd_row_10", 7'b1000001);
    tick_to(11);
    chk_o("rd_col_11", 7'b1001001);
    tick_to(12);
    chk_o("rd_cas_12", 7'b1111011);
    tick_to(19);
    chk_o("rd_cas_19", 7'b1111011);
    chk_p("rd_defer_19", bus_if.ref_pend, 3'd1);
    set_bus(1'b0, 1'b0, 1'b1, 1'b1);
    tick_to(20);
    chk_o("rd_pre_20", 7'b0000001);
    tick_to(21);
    chk_o("rd_pre_21", 7'b0000001);
    tick_to(22);
    chk_o("rd_idle_22", 7'b0000000);
    chk_p("rd_pend_22", bus_if.ref_pend, 3'd1);
    tick_to(23);
    chk_o("rd_refcas_23", 7'b0110001);

    // Byte write, low lane only
    do_reset();
    tick_to(4);
    set_bus(1'b1, 1'b1, 1'b0, 1'b1);
    tick_to(5);
    chk_o("wr_row_5", 7'b1000001);
    tick_to(6);
    chk_o("wr_col_6", 7'b1001101);
    tick_to(7);
    chk_o("wr_cas_7", 7'b1011111);
    set_bus(1'b0, 1'b0, 1'b0, 1'b1);
    tick_to(8);
    chk_o("wr_pre_8", 7'b0000001);
    tick_to(10);
    chk_o("wr_idle_10", 7'b0000000);

    // Abort in ACC_COL: no ACK ever
    set_bus(1'b1, 1'b1, 1'b1, 1'b1);
    tick_to(11);
    chk_o("ab_row_11", 7'b1000001);
    tick_to(12);
    chk_o("ab_col_12", 7'b1001101);
    set_bus(1'b0, 1'b0, 1'b1, 1'b1);
    tick_to(13);
    chk_o("ab_pre_13", 7'b0000001);
    tick_to(14);
    chk_o("ab_pre_14", 7'b0000001);
    tick_to(15);
    chk_o("ab_idle_15", 7'b0000000);

    // Continuous access starves refresh; backlog saturates at 4
    do_reset();
    set_bus(1'b1, 1'b0, 1'b1, 1'b1);
    maxp = 3'd0;
    while (cyc < 90) begin
      tick();
      if (bus_if.ref_pend > maxp) maxp = bus_if.ref_pend;
    end
    chk_p("st_max", maxp, 3'd4);
    chk_p("st_pend_90", bus_if.ref_pend, 3'd4);
    chk_o("st_cas_90", 7'b1111011);
    set_bus(1'b0, 1'b0, 1'b1, 1'b1);
    tick_to(91);
    chk_o("st_pre_91", 7'b0000001);
    set_bus(1'b1, 1'b0, 1'b1, 1'b1);
    tick_to(93);
    chk_o("st_idle_93", 7'b0000000);
    tick_to(94);
    chk_o("st_refcas_94", 7'b0110001);
    tick_to(95);
    chk_o("st_refras_95", 7'b1110001);
    chk_p("st_pend_95", bus_if.ref_pend, 3'd3);

    // Reset in the middle of REF_RAS
    reset = 1'b1;
    tick();
    chk_o("rr_outs", 7'b0000000);
    chk_p("rr_pend", bus_if.ref_pend, 3'd0);
    reset = 1'b0;
    set_bus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_o("rr_idle", 7'b0000000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
